// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle CPU control path: state codes, opcodes and datapath mux codes.
// Used by the control FSM, the datapath and the bench.
package mc_ctrl_pkg;

    localparam int OPCODE_SIZE = 6;
    localparam int STATE_SIZE  = 4;

    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_MEM_ADDR  = 4'd2,
        ST_MEM_READ  = 4'd3,
        ST_MEM_WB    = 4'd4,
        ST_MEM_WRITE = 4'd5,
        ST_EXECUTE   = 4'd6,
        ST_ALU_WB    = 4'd7,
        ST_BRANCH    = 4'd8,
        ST_JUMP      = 4'd9,
        ST_ADDI_EXEC = 4'd10,
        ST_ADDI_WB   = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [1:0] SRC_B_REG     = 2'b00;
    localparam logic [1:0] SRC_B_FOUR    = 2'b01;
    localparam logic [1:0] SRC_B_IMM     = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

    function automatic logic is_wait_state(input state_e s);
        return (s == ST_FETCH) || (s == ST_MEM_READ) || (s == ST_MEM_WRITE);
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory-handshake watchdog: counts consecutive stalled cycles and flags expiry on the last allowed one.
// WAIT_LIMIT = 0 disables expiry; the counter saturates instead of wrapping.
module mc_wait_timer #(
    parameter int WAIT_LIMIT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic expire
);

    localparam int CW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'((WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0);
    localparam logic [CW-1:0] SAT  = {CW{1'b1}};

    logic [CW-1:0] cnt_q, cnt_d;

    assign expire = (WAIT_LIMIT != 0) && inc && (cnt_q == LAST);

    // Expiry restarts the count so a retried FETCH gets a full window.
    always_comb begin
        cnt_d = cnt_q;
        if (clr || expire) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != SAT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle CPU: sequences each instruction and drives every datapath enable/mux.
// Define MC_CTRL_ADDI_EN to decode opcode 001000 (ADDI); otherwise it is reported as illegal.
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int OPCODE_SIZE = 6,
    parameter int STATE_SIZE  = 4,
    parameter int WAIT_LIMIT  = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [OPCODE_SIZE-1:0] opcode,
    input  logic                   mem_ready,
    output logic                   pc_write,
    output logic                   pc_write_cond,
    output logic [1:0]             pc_source,
    output logic                   i_or_d,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic                   ir_write,
    output logic                   mem_to_reg,
    output logic                   reg_dst,
    output logic                   reg_write,
    output logic                   alu_src_a,
    output logic [1:0]             alu_src_b,
    output logic [1:0]             alu_op,
    output logic                   illegal_op,
    output logic                   mem_timeout,
    output logic [STATE_SIZE-1:0]  state_out
);

    state_e state_q, state_d;
    logic   wait_inc, wait_clr, expire;

    // A stall is counted only while parked in a memory wait state.
    assign wait_inc = is_wait_state(state_q) && !mem_ready && !reset;
    assign wait_clr = reset || mem_ready || !is_wait_state(state_q);

    mc_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_wait_timer (
        .clk    (clk),
        .reset  (reset),
        .clr    (wait_clr),
        .inc    (wait_inc),
        .expire (expire)
    );

    always_comb begin
        state_d       = state_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = PC_SRC_ALU;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRC_B_REG;
        alu_op        = ALU_OP_ADD;
        illegal_op    = 1'b0;
        mem_timeout   = 1'b0;

        case (state_q)
            ST_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRC_B_FOUR;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = ST_DECODE;
                end else if (expire) begin
                    mem_timeout = 1'b1;
                end
            end
            ST_DECODE: begin
                alu_src_b = SRC_B_IMM_SH2;
                case (opcode)
                    OP_RTYPE:     state_d = ST_EXECUTE;
                    OP_LW, OP_SW: state_d = ST_MEM_ADDR;
                    OP_BEQ:       state_d = ST_BRANCH;
                    OP_J:         state_d = ST_JUMP;
`ifdef MC_CTRL_ADDI_EN
                    OP_ADDI:      state_d = ST_ADDI_EXEC;
`endif
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = ST_FETCH;
                    end
                endcase
            end
            ST_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_IMM;
                state_d   = (opcode == OP_SW) ? ST_MEM_WRITE : ST_MEM_READ;
            end
            ST_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) begin
                    state_d = ST_MEM_WB;
                end else if (expire) begin
                    mem_timeout = 1'b1;
                    state_d     = ST_FETCH;
                end
            end
            ST_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_MEM_WRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    state_d = ST_FETCH;
                end else if (expire) begin
                    mem_timeout = 1'b1;
                    state_d     = ST_FETCH;
                end
            end
            ST_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_OP_FUNCT;
                state_d   = ST_ALU_WB;
            end
            ST_ALU_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_OP_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PC_SRC_ALUOUT;
                state_d       = ST_FETCH;
            end
            ST_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PC_SRC_JUMP;
                state_d   = ST_FETCH;
            end
`ifdef MC_CTRL_ADDI_EN
            ST_ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_IMM;
                state_d   = ST_ADDI_WB;
            end
            ST_ADDI_WB: begin
                reg_write = 1'b1;
                state_d   = ST_FETCH;
            end
`endif
            default: state_d = ST_FETCH;
        endcase

        // Reset silences every request immediately, including an access in flight.
        if (reset) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            pc_source     = 2'b00;
            i_or_d        = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            mem_to_reg    = 1'b0;
            reg_dst       = 1'b0;
            reg_write     = 1'b0;
            alu_src_a     = 1'b0;
            alu_src_b     = 2'b00;
            alu_op        = 2'b00;
            illegal_op    = 1'b0;
            mem_timeout   = 1'b0;
        end
    end

    assign state_out = reset ? '0 : STATE_SIZE'(state_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control (WAIT_LIMIT=4): directed scenarios plus randomized
// instruction streams checked cycle by cycle against an instruction-level reference model.
module tb_multicycle_control;
    import mc_ctrl_pkg::*;

    localparam int LIM = 4;
`ifdef MC_CTRL_ADDI_EN
    localparam bit ADDI_ON = 1'b1;
`else
    localparam bit ADDI_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       mem_ready = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op, mem_timeout;
    logic [1:0] pc_source, alu_src_b, alu_op;
    logic [3:0] state_out;
    logic [15:0] outs;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         st;
        bit         mr;
        logic [5:0] opc;
        bit         ill;
        bit         tmo;
    } cyc_t;
    cyc_t q[$];

    always #5 clk = ~clk;

    multicycle_control #(.OPCODE_SIZE(6), .STATE_SIZE(4), .WAIT_LIMIT(LIM)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .illegal_op(illegal_op), .mem_timeout(mem_timeout), .state_out(state_out)
    );

    assign outs = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
                   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op};

    // Control word each state must present, straight from the state table.
    function automatic logic [15:0] exp_outs(input int st, input bit mr);
        logic pw, pwc, iod, rd_o, wr_o, irw, m2r, rdst, rw, a;
        logic [1:0] src, b, op;
        {pw, pwc, iod, rd_o, wr_o, irw, m2r, rdst, rw, a} = '0;
        src = 2'b00; b = 2'b00; op = 2'b00;
        case (st)
            0: begin rd_o = 1; b = 2'b01; irw = mr; pw = mr; end
            1: b = 2'b11;
            2: begin a = 1; b = 2'b10; end
            3: begin rd_o = 1; iod = 1; end
            4: begin rw = 1; m2r = 1; end
            5: begin wr_o = 1; iod = 1; end
            6: begin a = 1; op = 2'b10; end
            7: begin rw = 1; rdst = 1; end
            8: begin a = 1; op = 2'b01; pwc = 1; src = 2'b01; end
            9: begin pw = 1; src = 2'b10; end
            10: begin a = 1; b = 2'b10; end
            11: rw = 1;
            default: ;
        endcase
        return {pw, pwc, src, iod, rd_o, wr_o, irw, m2r, rdst, rw, a, b, op};
    endfunction

    task automatic push(input int st, input bit mr, input logic [5:0] opc, input bit ill, input bit tmo);
        cyc_t c;
        c.st = st; c.mr = mr; c.opc = opc; c.ill = ill; c.tmo = tmo;
        q.push_back(c);
    endtask

    task automatic test_reset();
        int exp_st[4] = '{0, 1, 6, 7};
        reset = 1'b1; mem_ready = 1'b1; opcode = OP_RTYPE;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            checks++;
            if (outs !== 16'h0 || illegal_op !== 1'b0 || mem_timeout !== 1'b0) begin
                errors++; $display("FAIL reset_outs got %h/%b/%b exp 0", outs, illegal_op, mem_timeout);
            end
            checks++;
            if (state_out !== 4'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state_out); end
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); reset = 1'b0; mem_ready = 1'b1; opcode = OP_RTYPE; #1;
            checks++;
            if (state_out !== 4'(exp_st[i])) begin
                errors++; $display("FAIL rtype_state step %0d got %0d exp %0d", i, state_out, exp_st[i]);
            end
            checks++;
            if (reg_write !== (exp_st[i] == 7) || reg_dst !== (exp_st[i] == 7)) begin
                errors++; $display("FAIL rtype_wb step %0d got %b%b exp %b", i, reg_write, reg_dst, exp_st[i] == 7);
            end
        end
    endtask

    task automatic test_lw_wait();
        int exp_st[8] = '{0, 1, 2, 3, 3, 3, 3, 4};
        bit mr_l[8]   = '{1, 1, 1, 0, 0, 0, 1, 1};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); mem_ready = mr_l[i]; opcode = OP_LW; #1;
            checks++;
            if (state_out !== 4'(exp_st[i])) begin
                errors++; $display("FAIL lw_state step %0d got %0d exp %0d", i, state_out, exp_st[i]);
            end
            checks++;
            if (mem_to_reg !== (exp_st[i] == 4) || mem_timeout !== 1'b0) begin
                errors++; $display("FAIL lw_m2r step %0d got %b/%b exp %b/0", i, mem_to_reg, mem_timeout, exp_st[i] == 4);
            end
        end
    endtask

    task automatic test_timeout();
        int exp_st[3] = '{1, 6, 7};
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk); mem_ready = 1'b0; opcode = 6'b111111; #1;
            checks++;
            if (state_out !== 4'd0 || ir_write !== 1'b0 || mem_timeout !== (k == 4)) begin
                errors++; $display("FAIL tmo_fetch cyc %0d got st%0d ir%b to%b exp st0 ir0 to%b", k, state_out, ir_write, mem_timeout, k == 4);
            end
        end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk); mem_ready = (k == 4); opcode = OP_RTYPE; #1;
            checks++;
            if (state_out !== 4'd0 || mem_timeout !== 1'b0 || ir_write !== (k == 4)) begin
                errors++; $display("FAIL tmo_rescue cyc %0d got st%0d ir%b to%b exp st0 ir%b to0", k, state_out, ir_write, mem_timeout, k == 4);
            end
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); mem_ready = 1'b0; #1;
            checks++;
            if (state_out !== 4'(exp_st[i]) || mem_timeout !== 1'b0) begin
                errors++; $display("FAIL tmo_after step %0d got %0d/%b exp %0d/0", i, state_out, mem_timeout, exp_st[i]);
            end
        end
    endtask

    task automatic test_illegal();
        bit exp_ill;
        for (int n = 0; n < 2; n++) begin
            logic [5:0] opc;
            opc = (n == 0) ? 6'b111111 : OP_ADDI;
            exp_ill = (n == 0) ? 1'b1 : !ADDI_ON;
            @(negedge clk); mem_ready = 1'b1; opcode = opc; #1;
            checks++;
            if (state_out !== 4'd0 || illegal_op !== 1'b0) begin
                errors++; $display("FAIL ill_fetch op %b got st%0d ill%b exp st0 ill0", opc, state_out, illegal_op);
            end
            @(negedge clk); #1;
            checks++;
            if (state_out !== 4'd1 || illegal_op !== exp_ill) begin
                errors++; $display("FAIL ill_decode op %b got st%0d ill%b exp st1 ill%b", opc, state_out, illegal_op, exp_ill);
            end
        end
        for (int i = 0; i < 2; i++) begin
            int exp_st;
            exp_st = exp_ill ? 0 : 10 + i;
            @(negedge clk); mem_ready = 1'b0; #1;
            checks++;
            if (state_out !== 4'(exp_st) || outs !== exp_outs(exp_st, 1'b0)) begin
                errors++; $display("FAIL addi_path step %0d got st%0d %h exp st%0d %h", i, state_out, outs, exp_st, exp_outs(exp_st, 1'b0));
            end
        end
        // Leave the DUT parked in FETCH with a clean watchdog for the next scenario.
        @(negedge clk); mem_ready = 1'b1; opcode = OP_J; #1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        checks++;
        if (state_out !== 4'd9) begin errors++; $display("FAIL ill_recover got %0d exp 9", state_out); end
    endtask

    task automatic test_branch_jump();
        for (int n = 0; n < 2; n++) begin
            @(negedge clk); mem_ready = 1'b1; opcode = (n == 0) ? OP_BEQ : OP_J; #1;
            @(negedge clk); #1;
            checks++;
            if (state_out !== 4'd1) begin errors++; $display("FAIL bj_decode got %0d exp 1", state_out); end
            @(negedge clk); #1;
            if (n == 0) begin
                checks++;
                if (state_out !== 4'd8 || pc_write_cond !== 1'b1 || pc_source !== 2'b01 || alu_op !== 2'b01 || pc_write !== 1'b0) begin
                    errors++; $display("FAIL beq got st%0d pwc%b src%b op%b pw%b exp st8 1 01 01 0", state_out, pc_write_cond, pc_source, alu_op, pc_write);
                end
            end else begin
                checks++;
                if (state_out !== 4'd9 || pc_write !== 1'b1 || pc_source !== 2'b10 || pc_write_cond !== 1'b0) begin
                    errors++; $display("FAIL jump got st%0d pw%b src%b pwc%b exp st9 1 10 0", state_out, pc_write, pc_source, pc_write_cond);
                end
            end
        end
    endtask

    task automatic test_reset_mid_write();
        int exp_st[5] = '{0, 1, 2, 5, 5};
        bit mr_l[5]   = '{1, 0, 1, 0, 0};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); mem_ready = mr_l[i]; opcode = OP_SW; #1;
            checks++;
            if (state_out !== 4'(exp_st[i]) || mem_write !== (exp_st[i] == 5)) begin
                errors++; $display("FAIL sw_state step %0d got st%0d mw%b exp st%0d", i, state_out, mem_write, exp_st[i]);
            end
        end
        @(negedge clk); reset = 1'b1; mem_ready = 1'b0; #1;
        checks++;
        if (outs !== 16'h0 || state_out !== 4'd0 || mem_timeout !== 1'b0) begin
            errors++; $display("FAIL rst_mid_outs got %h st%0d exp 0 st0", outs, state_out);
        end
        @(negedge clk); reset = 1'b0; mem_ready = 1'b1; opcode = OP_J; #1;
        checks++;
        if (state_out !== 4'd0 || ir_write !== 1'b1 || mem_write !== 1'b0) begin
            errors++; $display("FAIL rst_mid_after got st%0d ir%b mw%b exp st0 ir1 mw0", state_out, ir_write, mem_write);
        end
        @(negedge clk); #1;
        @(negedge clk); #1;
        checks++;
        if (state_out !== 4'd9) begin errors++; $display("FAIL rst_mid_jump got %0d exp 9", state_out); end
    endtask

    // Builds each instruction's expected cycle trace from its opcode and chosen stall lengths.
    task automatic test_random();
        for (int t = 0; t < 60; t++) begin
            int fw, mw, sel;
            logic [5:0] opc;
            bit legal;
            fw  = $urandom_range(0, 9);
            mw  = $urandom_range(0, 3);
            sel = $urandom_range(0, 6);
            case (sel)
                0: opc = OP_RTYPE;
                1: opc = OP_LW;
                2: opc = OP_SW;
                3: opc = OP_BEQ;
                4: opc = OP_J;
                5: opc = OP_ADDI;
                default: opc = {2'b11, 4'($urandom_range(0, 15))};
            endcase
            legal = (sel <= 4) || (sel == 5 && ADDI_ON);
            for (int k = 1; k <= fw; k++) push(0, 1'b0, 6'($urandom), 1'b0, (k % LIM) == 0);
            push(0, 1'b1, 6'($urandom), 1'b0, 1'b0);
            push(1, 1'($urandom), opc, !legal, 1'b0);
            if (legal) begin
                case (sel)
                    0: begin push(6, 1'($urandom), opc, 0, 0); push(7, 1'($urandom), opc, 0, 0); end
                    1: begin
                        push(2, 1'($urandom), opc, 0, 0);
                        for (int k = 0; k < mw; k++) push(3, 1'b0, opc, 0, 0);
                        push(3, 1'b1, opc, 0, 0);
                        push(4, 1'($urandom), opc, 0, 0);
                    end
                    2: begin
                        push(2, 1'($urandom), opc, 0, 0);
                        for (int k = 0; k < mw; k++) push(5, 1'b0, opc, 0, 0);
                        push(5, 1'b1, opc, 0, 0);
                    end
                    3: push(8, 1'($urandom), opc, 0, 0);
                    4: push(9, 1'($urandom), opc, 0, 0);
                    default: begin push(10, 1'($urandom), opc, 0, 0); push(11, 1'($urandom), opc, 0, 0); end
                endcase
            end
        end
        for (int n = 0; q.size() > 0; n++) begin
            cyc_t c;
            c = q.pop_front();
            @(negedge clk); mem_ready = c.mr; opcode = c.opc; #1;
            checks++;
            if (state_out !== 4'(c.st)) begin
                errors++; $display("FAIL rnd_state cyc %0d got %0d exp %0d", n, state_out, c.st);
            end
            checks++;
            if (outs !== exp_outs(c.st, c.mr)) begin
                errors++; $display("FAIL rnd_outs cyc %0d st %0d got %h exp %h", n, c.st, outs, exp_outs(c.st, c.mr));
            end
            checks++;
            if (illegal_op !== c.ill || mem_timeout !== c.tmo) begin
                errors++; $display("FAIL rnd_flags cyc %0d got ill%b to%b exp ill%b to%b", n, illegal_op, mem_timeout, c.ill, c.tmo);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lw_wait();
        test_timeout();
        test_illegal();
        test_branch_jump();
        test_reset_mid_write();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
